// File: rtl/truth_table_sweeper.sv
// Sweeps {A,B,C} through all eight vectors, holds each for HOLD_CYCLES cycles,
// captures F into a truth table and grades it against EXPECTED.
module truth_table_sweeper #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter logic [7:0]  EXPECTED    = 8'h8C
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    output logic       A,
    output logic       B,
    output logic       C,
    input  logic       F,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [7:0] TABLE,
    output logic [3:0] ERR_CNT,
    output logic [2:0] ERR_IDX
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [3:0] HoldLast = 4'(HOLD_CYCLES - 1);

    state_e     state_q, state_d;
    logic [2:0] vec_q, vec_d;
    logic [3:0] hold_q, hold_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [7:0] table_q, table_d;
    logic [3:0] err_cnt_q, err_cnt_d;
    logic [2:0] err_idx_q, err_idx_d;

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        hold_d    = hold_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        table_d   = table_q;
        err_cnt_d = err_cnt_q;
        err_idx_d = err_idx_q;

        case (state_q)
            StIdle, StDone: begin
                if (START) begin
                    state_d   = StRun;
                    vec_d     = 3'd0;
                    hold_d    = 4'd0;
                    table_d   = 8'h00;
                    err_cnt_d = 4'd0;
                    err_idx_d = 3'd0;
                    pass_d    = 1'b0;
                    done_d    = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            StRun: begin
                if (hold_q != HoldLast) begin
                    hold_d = hold_q + 4'd1;
                end else begin
                    hold_d         = 4'd0;
                    table_d[vec_q] = F;
                    if (F != EXPECTED[vec_q]) begin
                        err_cnt_d = err_cnt_q + 4'd1;
                        // Only the first mismatch of a sweep sets the index.
                        if (err_cnt_q == 4'd0) err_idx_d = vec_q;
                    end
                    if (vec_q == 3'd7) begin
                        state_d = StDone;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_cnt_d == 4'd0);
                    end else begin
                        vec_d = vec_q + 3'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            vec_q     <= 3'd0;
            hold_q    <= 4'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            table_q   <= 8'h00;
            err_cnt_q <= 4'd0;
            err_idx_q <= 3'd0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            hold_q    <= hold_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            table_q   <= table_d;
            err_cnt_q <= err_cnt_d;
            err_idx_q <= err_idx_d;
        end
    end

    assign {A, B, C} = vec_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign PASS      = pass_q;
    assign TABLE     = table_q;
    assign ERR_CNT   = err_cnt_q;
    assign ERR_IDX   = err_idx_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed + randomized bench for truth_table_sweeper, with one instance at
// HOLD_CYCLES=4 and one at HOLD_CYCLES=1.
module tb_truth_table_sweeper;

    localparam logic [7:0] Exp = 8'h8C;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_req = 1'b0;
    int   sel = 0;
    logic use_expr = 1'b1;
    logic [7:0] ftab = 8'h00;

    int checks = 0;
    int failures = 0;

    logic       a4, b4, c4, f4, busy4, done4, pass4;
    logic [7:0] tab4;
    logic [3:0] cnt4;
    logic [2:0] idx4;
    logic       a1, b1, c1, f1, busy1, done1, pass1;
    logic [7:0] tab1;
    logic [3:0] cnt1;
    logic [2:0] idx1;

    always #5 clk = ~clk;

    // Function under test: either the reference expression or an arbitrary table.
    assign f4 = use_expr ? ((~a4 & b4) | (b4 & c4)) : ftab[{a4, b4, c4}];
    assign f1 = use_expr ? ((~a1 & b1) | (b1 & c1)) : ftab[{a1, b1, c1}];

    truth_table_sweeper #(.HOLD_CYCLES(4), .EXPECTED(Exp)) dut4 (
        .CLK(clk), .RST(rst), .START(start_req && sel == 0),
        .A(a4), .B(b4), .C(c4), .F(f4),
        .BUSY(busy4), .DONE(done4), .PASS(pass4),
        .TABLE(tab4), .ERR_CNT(cnt4), .ERR_IDX(idx4)
    );

    truth_table_sweeper #(.HOLD_CYCLES(1), .EXPECTED(Exp)) dut1 (
        .CLK(clk), .RST(rst), .START(start_req && sel == 1),
        .A(a1), .B(b1), .C(c1), .F(f1),
        .BUSY(busy1), .DONE(done1), .PASS(pass1),
        .TABLE(tab1), .ERR_CNT(cnt1), .ERR_IDX(idx1)
    );

    logic [2:0] o_abc;
    logic       o_busy, o_done, o_pass;
    logic [7:0] o_tab;
    logic [3:0] o_cnt;
    logic [2:0] o_idx;
    assign o_abc  = (sel == 1) ? {a1, b1, c1} : {a4, b4, c4};
    assign o_busy = (sel == 1) ? busy1 : busy4;
    assign o_done = (sel == 1) ? done1 : done4;
    assign o_pass = (sel == 1) ? pass1 : pass4;
    assign o_tab  = (sel == 1) ? tab1 : tab4;
    assign o_cnt  = (sel == 1) ? cnt1 : cnt4;
    assign o_idx  = (sel == 1) ? idx1 : idx4;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] ref_table(input logic expr, input logic [7:0] t);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            int a, b, c;
            a = (i >> 2) & 1;
            b = (i >> 1) & 1;
            c = i & 1;
            r[i] = expr ? (((1 - a) & b) | (b & c)) != 0 : t[i];
        end
        return r;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_abc"},  32'(o_abc), 0);
        chk({tag, "_busy"}, 32'(o_busy), 0);
        chk({tag, "_done"}, 32'(o_done), 0);
        chk({tag, "_pass"}, 32'(o_pass), 0);
        chk({tag, "_tab"},  32'(o_tab), 0);
        chk({tag, "_cnt"},  32'(o_cnt), 0);
        chk({tag, "_idx"},  32'(o_idx), 0);
    endtask

    // Called at a negedge. Pulses START, then follows the sweep cycle by cycle.
    // start_n / rst_n (>=0) inject START / RST before edge k+start_n+1 / k+rst_n+1.
    task automatic sweep(input int h, input logic [7:0] want, input int start_n, input int rst_n);
        logic [7:0] diff;
        int exp_cnt, exp_idx;
        diff = want ^ Exp;
        exp_cnt = $countones(diff);
        exp_idx = 0;
        for (int i = 7; i >= 0; i--) if (diff[i]) exp_idx = i;

        start_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_req = 1'b0;
        chk("start_tab_clear", 32'(o_tab), 0);
        chk("start_cnt_clear", 32'(o_cnt), 0);
        chk("start_pass_clear", 32'(o_pass), 0);
        for (int n = 0; n < 8 * h; n++) begin
            chk("run_abc", 32'(o_abc), 32'(n / h));
            chk("run_busy", 32'(o_busy), 1);
            chk("run_done", 32'(o_done), 0);
            if (n == start_n) start_req = 1'b1;
            if (n == rst_n) rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start_req = 1'b0;
            if (n == rst_n) begin
                rst = 1'b0;
                chk_all_zero("rst_mid");
                for (int m = 0; m < 8 * h + 4; m++) begin
                    @(negedge clk);
                    chk("rst_no_done", 32'(o_done), 0);
                    chk("rst_no_busy", 32'(o_busy), 0);
                end
                return;
            end
        end
        chk("end_done", 32'(o_done), 1);
        chk("end_busy", 32'(o_busy), 0);
        chk("end_abc", 32'(o_abc), 7);
        chk("end_tab", 32'(o_tab), 32'(want));
        chk("end_cnt", 32'(o_cnt), 32'(exp_cnt));
        chk("end_idx", 32'(o_idx), 32'(exp_idx));
        chk("end_pass", 32'(o_pass), 32'(exp_cnt == 0));
        @(negedge clk);
        chk("done_level", 32'(o_done), 1);
        chk("done_abc_hold", 32'(o_abc), 7);
    endtask

    initial begin
        logic [7:0] t;
        // Reset with START high: nothing may start, all outputs zero.
        rst = 1'b1;
        start_req = 1'b1;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                sel = s;
                #0;
                chk_all_zero("reset");
            end
        end
        rst = 1'b0;
        start_req = 1'b0;
        sel = 0;
        @(negedge clk);
        chk_all_zero("idle");

        use_expr = 1'b1;
        sweep(4, ref_table(1'b1, 8'h00), -1, -1);
        use_expr = 1'b0;
        ftab = 8'h00;
        sweep(4, ref_table(1'b0, ftab), -1, -1);
        ftab = 8'hFF;
        sweep(4, ref_table(1'b0, ftab), -1, -1);

        for (int r = 0; r < 6; r++) begin
            sel = r % 2;
            t = 8'($urandom);
            ftab = t;
            @(negedge clk);
            sweep(sel == 1 ? 1 : 4, ref_table(1'b0, t), -1, -1);
        end

        // START at vector 3 is ignored; RST at vector 5 abandons the sweep.
        sel = 0;
        use_expr = 1'b1;
        @(negedge clk);
        sweep(4, ref_table(1'b1, 8'h00), 12, 20);

        // H=1 instance: reach DONE with a faulty table, then restart from DONE.
        sel = 1;
        use_expr = 1'b0;
        ftab = 8'h5A;
        @(negedge clk);
        sweep(1, ref_table(1'b0, ftab), -1, -1);
        use_expr = 1'b1;
        sweep(1, ref_table(1'b1, 8'h00), -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequential stimulus-and-capture stage wrapped around a 3-input combinational function block. It drives every {A,B,C} combination in ascending order, holds each vector for a programmable number of cycles, and samples the function output F back into an 8-bit captured truth table. At the end of the sweep it compares the table against an expected constant and reports pass/fail, the mismatch count and the first mismatching index. The default EXPECTED is the table of F = (~A & B) | (B & C).

## Interface
- HOLD_CYCLES, default 4: cycles each vector is driven; legal range 1..15.
- EXPECTED, default 8'h8C: expected truth table; bit i = expected F for {A,B,C} = i.

- CLK  in  1  rising-edge clock
- RST  in  1  synchronous, active-high reset
- START  in  1  begin sweep; sampled only in IDLE or DONE
- A  out  1  stimulus, MSB of vector index
- B  out  1  stimulus, middle bit
- C  out  1  stimulus, LSB
- F  in  1  function output under test; combinational from A, B, C
- BUSY  out  1  high while sweeping
- DONE  out  1  level; high from sweep completion until next START or RST
- PASS  out  1  TABLE == EXPECTED; valid only while DONE=1, otherwise 0
- TABLE  out  8  captured F values; bit i captured while vector i was driven
- ERR_CNT  out  4  number of mismatching bits, 0..8
- ERR_IDX  out  3  lowest mismatching index; 0 when ERR_CNT = 0

## Operation
- One clock and one reset. RST is synchronous and active-high.
- States: IDLE, RUN, DONE. All outputs are registered.
- Internal registers: vec (3 bits) and hold (4 bits).
- Reset values, all outputs 0: A=B=C=0, BUSY=0, DONE=0, PASS=0, TABLE=8'h00, ERR_CNT=0, ERR_IDX=0. State = IDLE.
- IDLE or DONE with START=1 at a rising edge:
  - Next state RUN; vec=0, hold=0.
  - TABLE, ERR_CNT, ERR_IDX and PASS cleared; DONE=0; BUSY=1.
- RUN, every cycle:
  - {A,B,C} = vec.
  - While hold < HOLD_CYCLES-1: hold increments.
  - When hold == HOLD_CYCLES-1: F is sampled into TABLE[vec] at that edge.
    - If F != EXPECTED[vec]: ERR_CNT increments; ERR_IDX is loaded with vec only when ERR_CNT was 0.
    - Then hold=0. If vec==7, next state is DONE; otherwise vec increments.
- Entering DONE:
  - BUSY=0, DONE=1, PASS = (ERR_CNT final == 0).
  - A,B,C hold the last vector, 3'b111, until the next START or RST.
- START while in RUN is ignored. The sweep continues unaffected.
- RST takes priority over START in every state. RST mid-sweep returns every output to its reset value at that edge, and the sweep is abandoned.
- ERR_CNT width covers all 8 mismatches; there is no saturation or wrap.

## Timing
- START sampled high at edge k:
  - BUSY=1 and vector 0 appear after edge k.
  - Vector i is driven during the cycles between edges k+i·H and k+(i+1)·H, where H = HOLD_CYCLES.
  - F for vector i is captured at edge k+(i+1)·H.
- DONE=1, PASS valid and BUSY=0 after edge k+8·H. With H=4, that is 32 edges after the START edge.
- With H=1, each vector lasts one cycle and F is sampled at the end of that same cycle. This is legal because F is combinational.
- START held high continuously:
  - From IDLE, it starts one sweep.
  - In DONE, it immediately restarts, so DONE is high for exactly one cycle.

## Test plan
- Reset: assert RST for 2 cycles with START=1.
  - Required: all outputs 0 and BUSY stays 0 throughout.
- Correct function, H=4: connect F = (~A&B)|(B&C) and pulse START.
  - Required: A,B,C step 000..111, 4 cycles each.
  - Required: DONE=1 exactly 32 edges after the START edge, TABLE=8'h8C, PASS=1, ERR_CNT=0, ERR_IDX=0.
- Faulty function: tie F=0.
  - Required: TABLE=8'h00, ERR_CNT=3, ERR_IDX=2, PASS=0.
- Faulty function: tie F=1.
  - Required: TABLE=8'hFF, ERR_CNT=5, ERR_IDX=0, PASS=0.
- Robustness: pulse START at vector 3, then assert RST at vector 5.
  - Required: the START at vector 3 has no effect on timing.
  - Required: after the RST edge, all outputs return to reset values and DONE never rises.
- Restart and H=1: in DONE, pulse START with F correct and HOLD_CYCLES=1.
  - Required: TABLE is cleared to 0 and DONE=0 on the next cycle.
  - Required: DONE=1 again 8 edges after the START edge, with PASS=1.
